// File: rtl/riscv_pkg.sv
// ----------------------------------------------------------------------------
// riscv_pkg
// Shared constants and types for the decode/execute boundary.
//   XLEN      : datapath width
//   NUM_REGS  : architectural register count
//   REG_AW    : register index width
//   alu_op_e  : ALU operation codes (NOP, AND, OR, ADD, SUB)
//   sanitize_alu_op : maps unsupported codes (101-111) onto NOP
// ----------------------------------------------------------------------------
package riscv_pkg;

    localparam int XLEN     = 32;
    localparam int NUM_REGS = 32;
    localparam int REG_AW   = 5;

    typedef enum logic [2:0] {
        ALU_NOP = 3'b000,
        ALU_AND = 3'b001,
        ALU_OR  = 3'b010,
        ALU_ADD = 3'b011,
        ALU_SUB = 3'b100
    } alu_op_e;

    // Codes 101-111 map onto NOP so that only defined operations reach the ALU.
    function automatic alu_op_e sanitize_alu_op(input logic [2:0] op);
        if (op > 3'(ALU_SUB)) begin
            return ALU_NOP;
        end
        return alu_op_e'(op);
    endfunction

endpackage : riscv_pkg

// File: rtl/id_ex_stage_if.sv
// ----------------------------------------------------------------------------
// id_ex_stage_if
// Bundles the decode-side inputs, writeback port and registered execute-side
// outputs of the ID/EX stage.
//   master : drives decode fields, stall/flush and writeback; observes outputs
//   slave  : the stage itself
// Handshake: valid_i marks a decoded instruction on the cycle it is presented;
// there is no ready -- the stage accepts whenever stall_i=0 and flush_i=0,
// and valid_o marks a live instruction held in the stage.
// ----------------------------------------------------------------------------
interface id_ex_stage_if
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN
);

    // decode side
    logic              valid_i;
    logic [4:0]        rs1_i;
    logic [4:0]        rs2_i;
    logic [4:0]        rd_i;
    logic [XLEN-1:0]   imm_i;
    logic              alu_src_i;
    logic [2:0]        alu_ctrl_i;
    logic              reg_write_i;
    logic              stall_i;
    logic              flush_i;

    // writeback port
    logic              wb_en_i;
    logic [4:0]        wb_addr_i;
    logic [XLEN-1:0]   wb_data_i;

    // execute side
    logic              valid_o;
    logic [XLEN-1:0]   a_o;
    logic [XLEN-1:0]   b_o;
    logic [XLEN-1:0]   rs2_data_o;
    logic [2:0]        alu_ctrl_o;
    logic [4:0]        rd_o;
    logic              reg_write_o;

    modport master (
        output valid_i, rs1_i, rs2_i, rd_i, imm_i, alu_src_i, alu_ctrl_i,
               reg_write_i, stall_i, flush_i, wb_en_i, wb_addr_i, wb_data_i,
        input  valid_o, a_o, b_o, rs2_data_o, alu_ctrl_o, rd_o, reg_write_o
    );

    modport slave (
        input  valid_i, rs1_i, rs2_i, rd_i, imm_i, alu_src_i, alu_ctrl_i,
               reg_write_i, stall_i, flush_i, wb_en_i, wb_addr_i, wb_data_i,
        output valid_o, a_o, b_o, rs2_data_o, alu_ctrl_o, rd_o, reg_write_o
    );

endinterface : id_ex_stage_if

// File: rtl/reg_file.sv
// ----------------------------------------------------------------------------
// reg_file
// 32 x XLEN register file, two combinational read ports, one write port.
//   clk_i, rst_i        : clock, asynchronous active-high reset (clears all)
//   we_i/waddr_i/wdata_i: write port; writes to x0 are dropped
//   raddr1_i/rdata1_o   : read port 1
//   raddr2_i/rdata2_o   : read port 2
// Reads of x0 return 0. A read of the index being written this cycle returns
// the write data (write-through bypass).
// ----------------------------------------------------------------------------
module reg_file
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            we_i,
    input  logic [4:0]      waddr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [4:0]      raddr1_i,
    input  logic [4:0]      raddr2_i,
    output logic [XLEN-1:0] rdata1_o,
    output logic [XLEN-1:0] rdata2_o
);

    logic [XLEN-1:0] regs_q [NUM_REGS];
    logic            wr_live;

    assign wr_live = we_i && (waddr_i != 5'd0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_live) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // x0 check first so the bypass can never leak a value onto index 0.
    always_comb begin
        rdata1_o = regs_q[raddr1_i];
        if (raddr1_i == 5'd0) begin
            rdata1_o = '0;
        end else if (wr_live && (waddr_i == raddr1_i)) begin
            rdata1_o = wdata_i;
        end
    end

    always_comb begin
        rdata2_o = regs_q[raddr2_i];
        if (raddr2_i == 5'd0) begin
            rdata2_o = '0;
        end else if (wr_live && (waddr_i == raddr2_i)) begin
            rdata2_o = wdata_i;
        end
    end

endmodule : reg_file

// File: rtl/id_ex_stage.sv
// ----------------------------------------------------------------------------
// id_ex_stage
// Decode/execute pipeline register with the integer register file.
//   clk_i : clock, all state on rising edge
//   rst_i : asynchronous active-high reset; clears file and outputs
//   bus   : id_ex_stage_if.slave (decode fields, stall/flush, writeback,
//           registered operands and control)
// Update priority each edge: flush > stall (hold) > load.
// Writeback into the file happens regardless of stall or flush.
// ----------------------------------------------------------------------------
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic                clk_i,
    input  logic                rst_i,
    id_ex_stage_if.slave        bus
);

    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;

    reg_file #(.XLEN(XLEN)) u_reg_file (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .we_i     (bus.wb_en_i),
        .waddr_i  (bus.wb_addr_i),
        .wdata_i  (bus.wb_data_i),
        .raddr1_i (bus.rs1_i),
        .raddr2_i (bus.rs2_i),
        .rdata1_o (rs1_val),
        .rdata2_o (rs2_val)
    );

    logic            valid_q,     valid_d;
    logic [XLEN-1:0] a_q,         a_d;
    logic [XLEN-1:0] b_q,         b_d;
    logic [XLEN-1:0] rs2_data_q,  rs2_data_d;
    alu_op_e         alu_ctrl_q,  alu_ctrl_d;
    logic [4:0]      rd_q,        rd_d;
    logic            reg_write_q, reg_write_d;

    // Next-state: default is hold, which covers the stall case. Held operands
    // are deliberately not refreshed by later writebacks.
    always_comb begin
        valid_d     = valid_q;
        a_d         = a_q;
        b_d         = b_q;
        rs2_data_d  = rs2_data_q;
        alu_ctrl_d  = alu_ctrl_q;
        rd_d        = rd_q;
        reg_write_d = reg_write_q;

        if (bus.flush_i) begin
            valid_d     = 1'b0;
            a_d         = '0;
            b_d         = '0;
            rs2_data_d  = '0;
            alu_ctrl_d  = ALU_NOP;
            rd_d        = 5'd0;
            reg_write_d = 1'b0;
        end else if (!bus.stall_i) begin
            valid_d    = bus.valid_i;
            a_d        = rs1_val;
            rs2_data_d = rs2_val;
            b_d        = bus.alu_src_i ? bus.imm_i : rs2_val;
            rd_d       = bus.rd_i;
            // A bubble must not write back or drive an ALU operation; its
            // operand fields still load so the register contents stay
            // a pure function of the inputs.
            if (bus.valid_i) begin
                alu_ctrl_d  = sanitize_alu_op(bus.alu_ctrl_i);
                reg_write_d = bus.reg_write_i;
            end else begin
                alu_ctrl_d  = ALU_NOP;
                reg_write_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            rs2_data_q  <= '0;
            alu_ctrl_q  <= ALU_NOP;
            rd_q        <= 5'd0;
            reg_write_q <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            a_q         <= a_d;
            b_q         <= b_d;
            rs2_data_q  <= rs2_data_d;
            alu_ctrl_q  <= alu_ctrl_d;
            rd_q        <= rd_d;
            reg_write_q <= reg_write_d;
        end
    end

    assign bus.valid_o     = valid_q;
    assign bus.a_o         = a_q;
    assign bus.b_o         = b_q;
    assign bus.rs2_data_o  = rs2_data_q;
    assign bus.alu_ctrl_o  = alu_ctrl_q;
    assign bus.rd_o        = rd_q;
    assign bus.reg_write_o = reg_write_q;

endmodule : id_ex_stage

// File: tb/tb_id_ex_stage.sv
// ----------------------------------------------------------------------------
// tb_id_ex_stage
// Directed scenarios followed by randomized traffic, checked against a
// register-array reference model of the stage.
// ----------------------------------------------------------------------------
module tb_id_ex_stage;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    id_ex_stage_if #(.XLEN(32)) bus ();

    id_ex_stage #(.XLEN(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    logic [31:0] rf_m [32];
    logic        e_valid;
    logic [31:0] e_a, e_b, e_rs2;
    logic [2:0]  e_ctrl;
    logic [4:0]  e_rd;
    logic        e_rw;
    logic        e_dc;     // operand fields and rd are don't-care (bubble load)

    function automatic logic [31:0] model_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
        if (bus.wb_en_i && bus.wb_addr_i == idx) return bus.wb_data_i;
        return rf_m[idx];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) rf_m[i] = 32'd0;
        e_valid = 1'b0; e_a = 0; e_b = 0; e_rs2 = 0;
        e_ctrl = 3'd0; e_rd = 5'd0; e_rw = 1'b0; e_dc = 1'b0;
    endtask

    // Computes what the stage must show after the coming edge, then applies
    // the writeback to the model file.
    task automatic model_predict();
        logic [31:0] v1, v2;
        v1 = model_read(bus.rs1_i);
        v2 = model_read(bus.rs2_i);
        if (bus.flush_i) begin
            e_valid = 1'b0; e_a = 0; e_b = 0; e_rs2 = 0;
            e_ctrl = 3'd0; e_rd = 5'd0; e_rw = 1'b0; e_dc = 1'b0;
        end else if (!bus.stall_i) begin
            e_valid = bus.valid_i;
            e_a     = v1;
            e_rs2   = v2;
            e_b     = bus.alu_src_i ? bus.imm_i : v2;
            e_rd    = bus.rd_i;
            e_dc    = !bus.valid_i;
            e_rw    = bus.valid_i ? bus.reg_write_i : 1'b0;
            e_ctrl  = (bus.valid_i && bus.alu_ctrl_i <= 3'd4) ? bus.alu_ctrl_i : 3'd0;
        end
        if (bus.wb_en_i && bus.wb_addr_i != 5'd0) rf_m[bus.wb_addr_i] = bus.wb_data_i;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".valid"}, 32'(bus.valid_o), 32'(e_valid));
        check({tag, ".rw"},    32'(bus.reg_write_o), 32'(e_rw));
        check({tag, ".ctrl"},  32'(bus.alu_ctrl_o), 32'(e_ctrl));
        if (!e_dc) begin
            check({tag, ".a"},   bus.a_o, e_a);
            check({tag, ".b"},   bus.b_o, e_b);
            check({tag, ".rs2"}, bus.rs2_data_o, e_rs2);
            check({tag, ".rd"},  32'(bus.rd_o), 32'(e_rd));
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_dec(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                             input logic [4:0] rd, input logic [31:0] imm, input logic src,
                             input logic [2:0] ctrl, input logic rw);
        bus.valid_i = v; bus.rs1_i = r1; bus.rs2_i = r2; bus.rd_i = rd;
        bus.imm_i = imm; bus.alu_src_i = src; bus.alu_ctrl_i = ctrl; bus.reg_write_i = rw;
    endtask

    task automatic drive_ctl(input logic st, input logic fl, input logic we,
                             input logic [4:0] wa, input logic [31:0] wd);
        bus.stall_i = st; bus.flush_i = fl;
        bus.wb_en_i = we; bus.wb_addr_i = wa; bus.wb_data_i = wd;
    endtask

    // One clock: predict, take the edge, sample 2 time units later.
    task automatic cycle(input string tag);
        model_predict();
        @(posedge clk);
        #2;
        check_all(tag);
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] s_a, s_b, s_rs2;
    logic [2:0]  s_ctrl;

    initial begin
        model_reset();
        drive_dec(0, 0, 0, 0, 0, 0, 0, 0);
        drive_ctl(0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #2;
        check_all("reset");
        rst = 1'b0;

        // write x5, then read it through rs1
        drive_ctl(0, 0, 1, 5'd5, 32'h1234);
        cycle("wb_x5");
        drive_ctl(0, 0, 0, 0, 0);
        drive_dec(1, 5'd5, 5'd0, 5'd1, 32'h0, 0, 3'b011, 1);
        cycle("load_x5");
        check("x5_a", bus.a_o, 32'h1234);
        check("x5_b", bus.b_o, 32'h0);
        check("x5_valid", 32'(bus.valid_o), 32'd1);

        // same-cycle bypass on rs2
        drive_ctl(0, 0, 1, 5'd7, 32'hDEADBEEF);
        drive_dec(1, 5'd5, 5'd7, 5'd2, 32'h0, 0, 3'b100, 1);
        cycle("bypass_x7");
        check("bypass_b", bus.b_o, 32'hDEADBEEF);
        check("bypass_rs2", bus.rs2_data_o, 32'hDEADBEEF);

        // x0 write dropped, immediate selected
        drive_ctl(0, 0, 1, 5'd0, 32'hFFFFFFFF);
        drive_dec(0, 0, 0, 0, 0, 0, 0, 0);
        cycle("wb_x0");
        drive_ctl(0, 0, 0, 0, 0);
        drive_dec(1, 5'd0, 5'd7, 5'd3, 32'hFFFFF800, 1, 3'b001, 1);
        cycle("x0_imm");
        check("x0_a", bus.a_o, 32'h0);
        check("imm_b", bus.b_o, 32'hFFFFF800);

        // stall 3 cycles with changing inputs and a writeback to x7
        s_a = e_a; s_b = e_b; s_rs2 = e_rs2; s_ctrl = e_ctrl;
        for (int i = 0; i < 3; i++) begin
            drive_ctl(1, 0, 1, 5'd7, 32'h1111_0000 + 32'(i));
            drive_dec(1, 5'd5, 5'd7, 5'(10 + i), 32'(i), 0, 3'b010, 1);
            cycle("stall");
            check("stall_a", bus.a_o, s_a);
            check("stall_b", bus.b_o, s_b);
            check("stall_rs2", bus.rs2_data_o, s_rs2);
            check("stall_ctrl", 32'(bus.alu_ctrl_o), 32'(s_ctrl));
        end
        // flush wins over stall
        drive_ctl(1, 1, 0, 0, 0);
        cycle("flush_stall");
        check("flush_valid", 32'(bus.valid_o), 32'd0);
        check("flush_ctrl", 32'(bus.alu_ctrl_o), 32'd0);
        check("flush_rw", 32'(bus.reg_write_o), 32'd0);

        // held writeback of x7 during stall still reached the file
        drive_ctl(0, 0, 0, 0, 0);
        drive_dec(1, 5'd7, 5'd5, 5'd4, 32'h0, 0, 3'b110, 1);
        cycle("op110");
        check("op110_ctrl", 32'(bus.alu_ctrl_o), 32'd0);
        check("x7_after_stall", bus.a_o, 32'h1111_0002);

        // live load, then stall, then async reset mid-cycle
        drive_dec(1, 5'd5, 5'd7, 5'd9, 32'h0, 0, 3'b011, 1);
        cycle("pre_rst");
        drive_ctl(1, 0, 0, 0, 0);
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        check("rst_valid", 32'(bus.valid_o), 32'd0);
        check("rst_a", bus.a_o, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        drive_ctl(0, 0, 0, 0, 0);
        drive_dec(1, 5'd5, 5'd7, 5'd1, 32'h0, 0, 3'b001, 1);
        cycle("post_rst");
        check("rst_x5", bus.a_o, 32'h0);

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            logic [4:0] wa;
            wa = 5'($urandom_range(0, 31));
            drive_ctl($urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
                      $urandom_range(0, 1) == 1, wa, $urandom);
            drive_dec($urandom_range(0, 3) != 0,
                      ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31)),
                      ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31)),
                      5'($urandom_range(0, 31)), $urandom, $urandom_range(0, 1) == 1,
                      3'($urandom_range(0, 7)), $urandom_range(0, 1) == 1);
            cycle("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_id_ex_stage
